shift_add_ctrl: RTL and testbench
=================================

// Module: shift_add_ctrl
// PURPOSE
//   Parametrised Moore controller for the shift-and-add multiplier datapath.
//   Adds a start/busy/done handshake, an iteration counter bounded by WIDTH,
//   and optional early exit when the multiplier register reaches zero.
//   Drives the datapath control word; the datapath returns lsb/zero status.
// PARAMETERS
//   WIDTH      16  operand width; maximum number of shift iterations (>=2)
//   EARLY_EXIT 1   1: finish as soon as zero=1 at CHECK; 0: always WIDTH iterations
//   CNTW       $clog2(WIDTH+1)  iteration counter width (derived, localparam)
// PORTS
//   clk       in   1     system clock, rising edge
//   rst       in   1     synchronous, active-high reset
//   start     in   1     request a multiply; sampled only in IDLE
//   lsb       in   1     multiplier LSB from datapath (parity)
//   zero      in   1     multiplier register == 0 from datapath
//   o_signal  out  16    control word: [14:13] cnt_alu, [12:9] slc_mux_a,
//                        [8:5] slc_mux_b, [4:1] slc_reg, [0] w; [15] always 0
//   busy      out  1     high from LOAD through CHECK inclusive
//   done      out  1     one-cycle pulse in DONE
//   iter      out  CNTW  completed shift iterations of the current operation
// BEHAVIOUR
//   Single clock; all state updates on rising clk. rst=1 at an edge -> state
//   IDLE, iter=0, regardless of current state (mid-operation abort, no done).
//   Outputs decoded from the state register only (Moore), so o_signal=0,
//   busy=0, done=0 in the cycle after reset.
//   States / o_signal / transitions:
//     IDLE  16'h0000  start ? LOAD : IDLE
//     LOAD  16'h0003  iter<=0; -> TEST  (load operands, clear accumulator)
//     TEST  16'h6200  lsb ? ADD : SHIFT
//     ADD   16'h0201  -> SHIFT          (accumulator += multiplicand)
//     SHIFT 16'h4203  iter<=iter+1; -> CHECK
//     CHECK 16'h0249  (iter==WIDTH) || (EARLY_EXIT && zero) ? DONE : TEST
//     DONE  16'h0000  done=1; -> IDLE unconditionally
//     illegal encodings -> IDLE, o_signal=0.
//   busy=1 in LOAD,TEST,ADD,SHIFT,CHECK. done=1 only in DONE.
//   start ignored outside IDLE (incl. DONE); a held start restarts only after
//   returning to IDLE, so min spacing between done pulses is one IDLE cycle.
//   lsb sampled only in TEST, zero only in CHECK; other times don't-care.
//   iter saturates by construction at WIDTH (never wraps); holds value through
//   DONE and IDLE until next LOAD.
//   Latency from start edge: LOAD is cycle 1; each iteration takes 3 cycles
//   (lsb=0) or 4 (lsb=1); DONE follows the final CHECK.
//   Worst case (EARLY_EXIT=0, all lsb=1): 4*WIDTH+2 cycles to done.
//   rst and start asserted together: rst wins, stays IDLE.
// TESTING
//   1 rst held 2 cycles in any state -> o_signal=0, busy=0, done=0, iter=0.
//   2 WIDTH=4, EARLY_EXIT=0, lsb seq 1,0,1,1 -> word seq 0003,(6200,0201,4203,
//     0249),(6200,4203,0249),... done high in cycle 17, iter=4.
//   3 WIDTH=16, EARLY_EXIT=1, lsb=1, zero=1 at first CHECK -> done cycle 6, iter=1.
//   4 Same as 3 with EARLY_EXIT=0 -> zero ignored; done only when iter=16.
//   5 start pulsed in TEST and held high through DONE -> no restart until IDLE;
//     exactly one IDLE cycle, then LOAD.
//   6 rst asserted in ADD -> next cycle IDLE, o_signal=0, no done pulse; new
//     start afterwards completes normally.

Source files
------------

// File: rtl/shift_add_ctrl.sv
// Moore sequencer for the shift-and-add multiplier datapath: start/busy/done
// handshake, WIDTH-bounded iteration count, optional early exit on zero.
module shift_add_ctrl #(
  parameter int  WIDTH      = 16,
  parameter bit  EARLY_EXIT = 1'b1,
  localparam int CNTW       = $clog2(WIDTH+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            lsb,
  input  logic            zero,
  output logic [15:0]     o_signal,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] iter
);

  localparam logic [CNTW-1:0] ITER_MAX = CNTW'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_CHECK = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t state, state_nx;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // iter is only advanced by SHIFT and CHECK exits at WIDTH, so it never wraps
  always_ff @(posedge clk) begin
    if (rst)                   iter <= '0;
    else if (state == S_LOAD)  iter <= '0;
    else if (state == S_SHIFT) iter <= iter + CNTW'(1);
  end

  always_comb begin
    state_nx = S_IDLE;
    o_signal = 16'h0000;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE:  state_nx = start ? S_LOAD : S_IDLE;
      S_LOAD: begin
        o_signal = 16'h0003;
        busy     = 1'b1;
        state_nx = S_TEST;
      end
      S_TEST: begin
        o_signal = 16'h6200;
        busy     = 1'b1;
        state_nx = lsb ? S_ADD : S_SHIFT;
      end
      S_ADD: begin
        o_signal = 16'h0201;
        busy     = 1'b1;
        state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        o_signal = 16'h4203;
        busy     = 1'b1;
        state_nx = S_CHECK;
      end
      S_CHECK: begin
        o_signal = 16'h0249;
        busy     = 1'b1;
        state_nx = ((iter == ITER_MAX) || (EARLY_EXIT && zero)) ? S_DONE : S_TEST;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_add_ctrl.sv
// Randomised bench for shift_add_ctrl: three parameterisations checked every
// cycle against a per-operation expected-trace model built from the op rules.
module tb_shift_add_ctrl;

  localparam int NU = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NU-1:0]       rst, start, lsb, zero, busy, done;
  logic [NU-1:0][15:0] osig;
  logic [NU-1:0][4:0]  itw;

  // unit 0: WIDTH=4 no early exit; unit 1: WIDTH=16 early exit; unit 2: WIDTH=16 no early exit
  for (genvar g = 0; g < NU; g++) begin : gu
    localparam int GW = (g == 0) ? 4 : 16;
    localparam bit GE = (g == 1);
    logic [$clog2(GW+1)-1:0] it;
    shift_add_ctrl #(.WIDTH(GW), .EARLY_EXIT(GE)) u_dut (
      .clk(clk), .rst(rst[g]), .start(start[g]), .lsb(lsb[g]), .zero(zero[g]),
      .o_signal(osig[g]), .busy(busy[g]), .done(done[g]), .iter(it)
    );
    assign itw[g] = 5'(it);
  end

  function automatic int wof(int g);  return (g == 0) ? 4 : 16; endfunction
  function automatic bit eeof(int g); return (g == 1);          endfunction

  typedef struct {
    logic [15:0] w;
    bit          b;
    bit          d;
    int          it;
    bit          l;
    bit          z;
  } ent_t;

  ent_t        plan[$];
  logic [15:0] ew[NU];
  bit          eb[NU], ed[NU];
  int          ei[NU], prev_iter[NU];
  bit          chk_on;
  int          total, bad;

  task automatic chk(string nm, int g, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s unit%0d t=%0t got=%0h want=%0h", nm, g, $time, act, exp);
    end
  endtask

  function automatic ent_t mk(logic [15:0] w, bit b, bit d, int it, bit l, bit z);
    ent_t e;
    e.w = w; e.b = b; e.d = d; e.it = it; e.l = l; e.z = z;
    return e;
  endfunction

  // Expected cycle-by-cycle trace of one operation, starting at the LOAD cycle.
  // Each iteration is TEST, optional ADD, SHIFT, CHECK; zero is driven high at
  // the CHECK closing iteration number zat.
  function automatic void build(int w, bit ee, logic [15:0] lsbv, int zat, int prev);
    int n;
    plan.delete();
    plan.push_back(mk(16'h0003, 1, 0, prev, 1'($urandom), 1'($urandom)));
    n = 0;
    forever begin
      bit zc;
      plan.push_back(mk(16'h6200, 1, 0, n, lsbv[n], 1'($urandom)));
      if (lsbv[n]) plan.push_back(mk(16'h0201, 1, 0, n, 1'($urandom), 1'($urandom)));
      plan.push_back(mk(16'h4203, 1, 0, n, 1'($urandom), 1'($urandom)));
      n++;
      zc = (n == zat);
      plan.push_back(mk(16'h0249, 1, 0, n, 1'($urandom), zc));
      if (n == w || (ee && zc)) break;
    end
    plan.push_back(mk(16'h0000, 0, 1, n, 1'($urandom), 1'($urandom)));
  endfunction

  task automatic setexp(int g, logic [15:0] w, bit b, bit d, int it);
    ew[g] = w; eb[g] = b; ed[g] = d; ei[g] = it;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int g = 0; g < NU; g++) begin
      lsb[g]  = 1'($urandom);
      zero[g] = 1'($urandom);
    end
  endtask

  // Runs one operation on unit g from an IDLE cycle. abort>=0 asserts rst for
  // two cycles starting at that trace index. hold keeps start high through DONE.
  task automatic run_op(int g, logic [15:0] lsbv, int zat, bit hold, int abort,
                        output int dcyc);
    ent_t e;
    dcyc = -1;
    build(wof(g), eeof(g), lsbv, zat, prev_iter[g]);
    start[g] = 1'b1;
    for (int k = 0; k < plan.size(); k++) begin
      tick();
      e = plan[k];
      setexp(g, e.w, e.b, e.d, e.it);
      lsb[g]  = e.l;
      zero[g] = e.z;
      if (k == abort) begin
        rst[g] = 1'b1;
        start[g] = 1'($urandom);
        tick();
        setexp(g, 16'h0000, 0, 0, 0);
        start[g] = 1'($urandom);
        tick();
        rst[g] = 1'b0;
        start[g] = 1'b0;
        prev_iter[g] = 0;
        return;
      end
      start[g] = e.d ? hold : 1'($urandom);
      if (e.d) dcyc = k + 1;
    end
    prev_iter[g] = plan[plan.size()-1].it;
    tick();
    setexp(g, 16'h0000, 0, 0, prev_iter[g]);
    if (!hold) start[g] = 1'b0;
  endtask

  initial begin
    int dc;
    logic [15:0] ref2 [9];
    rst = '1; start = '0; lsb = '0; zero = '0;
    chk_on = 1'b0; total = 0; bad = 0;
    for (int g = 0; g < NU; g++) begin
      setexp(g, 16'h0000, 0, 0, 0);
      prev_iter[g] = 0;
    end
    fork
      forever begin
        @(negedge clk);
        if (chk_on)
          for (int g = 0; g < NU; g++) begin
            chk("word", g, osig[g], ew[g]);
            chk("busy", g, busy[g], eb[g]);
            chk("done", g, done[g], ed[g]);
            chk("iter", g, itw[g], ei[g]);
          end
      end
    join_none

    // reset held two cycles, start requested at the same time: stays idle
    start = '1;
    tick(); chk_on = 1'b1;
    tick(); rst = '0; start = '0;
    tick();

    // WIDTH=4, lsb sequence 1,0,1,1
    run_op(0, 16'b1101, 99, 0, -1, dc);
    chk("t2_done_cycle", 0, dc, 17);
    chk("t2_iter", 0, itw[0], 4);
    ref2 = '{16'h0003, 16'h6200, 16'h0201, 16'h4203, 16'h0249,
             16'h6200, 16'h4203, 16'h0249, 16'h6200};
    for (int k = 0; k < 9; k++) chk("t2_trace", 0, plan[k].w, ref2[k]);
    tick();

    // zero at first CHECK: early exit vs. full 16 iterations
    run_op(1, 16'hFFFF, 1, 0, -1, dc);
    chk("t3_done_cycle", 1, dc, 6);
    chk("t3_iter", 1, itw[1], 1);
    run_op(2, 16'hFFFF, 1, 0, -1, dc);
    chk("t4_done_cycle", 2, dc, 66);
    chk("t4_iter", 2, itw[2], 16);

    // start held through DONE: exactly one IDLE cycle, then a fresh LOAD
    run_op(1, 16'h0005, 3, 1, -1, dc);
    run_op(1, 16'h0003, 2, 0, -1, dc);
    chk("t5_done_cycle", 1, dc, 10);

    // reset during ADD aborts without done; the next operation runs normally
    run_op(0, 16'h0001, 99, 0, 2, dc);
    chk("t6_abort_nodone", 0, dc, -1);
    tick();
    run_op(0, 16'h0000, 99, 0, -1, dc);
    chk("t6_done_cycle", 0, dc, 14);

    for (int n = 0; n < 45; n++) begin
      int g, ab, gap;
      bit hold;
      g    = $urandom_range(0, NU-1);
      hold = ($urandom_range(0, 3) == 0);
      ab   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 12) : -1;
      run_op(g, 16'($urandom), $urandom_range(1, wof(g) + 2), hold, ab, dc);
      if (hold && ab < 0)
        run_op(g, 16'($urandom), $urandom_range(1, wof(g) + 2), 0, -1, dc);
      gap = $urandom_range(0, 3);
      for (int i = 0; i < gap; i++) tick();
    end

    tick();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
